// File: rtl/ppi_ctrl_unit.sv
// PPI control-word unit: decodes mode-set and bit-set/reset commands written over the bus
// and drives the port mode, direction and port C latch controls, all from registers.
module ppi_ctrl_unit #(
    parameter int         PC_W     = 8,
    parameter logic [7:0] RST_WORD = 8'h9B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in,
    input  logic            en,
    output logic [7:0]      word,
    output logic [1:0]      mode_a,
    output logic            mode_b,
    output logic            dir_a,
    output logic            dir_b,
    output logic            dir_cu,
    output logic            dir_cl,
    output logic [PC_W-1:0] pc_out,
    output logic            clr_latch,
    output logic            cfg_valid,
    output logic            bsr_err
);

    localparam logic [3:0] PC_LIM = 4'(PC_W);

    // Reset decode matches what a mode-set of RST_WORD would have produced.
    localparam logic [1:0] RST_MODE_A = RST_WORD[6] ? 2'b10 : {1'b0, RST_WORD[5]};

    logic            en_d;
    logic            wr;
    logic            mode_wr;
    logic            bsr_wr;
    logic            bsr_ok;
    logic [PC_W-1:0] pc_next;

    assign wr      = en & ~en_d;
    assign mode_wr = wr & in[7];
    assign bsr_wr  = wr & ~in[7];
    assign bsr_ok  = {1'b0, in[3:1]} < PC_LIM;

    always_comb begin
        pc_next = pc_out;
        for (int i = 0; i < PC_W; i++) begin
            if (in[3:1] == 3'(i)) begin
                pc_next[i] = in[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d <= 1'b0;
        end else begin
            en_d <= en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= RST_WORD;
            mode_a    <= RST_MODE_A;
            dir_a     <= RST_WORD[4];
            dir_cu    <= RST_WORD[3];
            mode_b    <= RST_WORD[2];
            dir_b     <= RST_WORD[1];
            dir_cl    <= RST_WORD[0];
            cfg_valid <= 1'b0;
        end else if (mode_wr) begin
            word      <= in;
            mode_a    <= in[6] ? 2'b10 : {1'b0, in[5]};
            dir_a     <= in[4];
            dir_cu    <= in[3];
            mode_b    <= in[2];
            dir_b     <= in[1];
            dir_cl    <= in[0];
            cfg_valid <= 1'b1;
        end
    end

    // Mode-set clears the whole port C latch; BSR touches one bit only when it is in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out <= '0;
        end else if (mode_wr) begin
            pc_out <= '0;
        end else if (bsr_wr && bsr_ok) begin
            pc_out <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_latch <= 1'b0;
            bsr_err   <= 1'b0;
        end else begin
            clr_latch <= mode_wr;
            bsr_err   <= bsr_wr & ~bsr_ok;
        end
    end

endmodule

// File: tb/tb_ppi_ctrl_unit.sv
// Bench for ppi_ctrl_unit: one 8-bit and one 4-bit port C instance share the same bus,
// checked against hand-written vectors, corner sequences and a behavioural model.
module tb_ppi_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       en;

   logic [7:0] word8, word4;
   logic [1:0] mode_a8, mode_a4;
   logic       mode_b8, mode_b4;
   logic       dir_a8, dir_b8, dir_cu8, dir_cl8;
   logic       dir_a4, dir_b4, dir_cu4, dir_cl4;
   logic [7:0] pc8;
   logic [3:0] pc4;
   logic       clr8, clr4, cfg8, cfg4, err8, err4;

   int checks = 0;
   int errors = 0;

   // Behavioural model state, updated once per clock from the command rules.
   int m_word, m_pc8, m_pc4;
   bit m_cfg, m_clr, m_err8, m_err4, m_prev_en;

   always #5 clk = ~clk;

   ppi_ctrl_unit #(.PC_W(8)) dut8 (
      .clk(clk), .rst(rst), .in(din), .en(en), .word(word8),
      .mode_a(mode_a8), .mode_b(mode_b8), .dir_a(dir_a8), .dir_b(dir_b8),
      .dir_cu(dir_cu8), .dir_cl(dir_cl8), .pc_out(pc8), .clr_latch(clr8),
      .cfg_valid(cfg8), .bsr_err(err8)
   );

   ppi_ctrl_unit #(.PC_W(4)) dut4 (
      .clk(clk), .rst(rst), .in(din), .en(en), .word(word4),
      .mode_a(mode_a4), .mode_b(mode_b4), .dir_a(dir_a4), .dir_b(dir_b4),
      .dir_cu(dir_cu4), .dir_cl(dir_cl4), .pc_out(pc4), .clr_latch(clr4),
      .cfg_valid(cfg4), .bsr_err(err4)
   );

   typedef struct {
      bit         rst;
      bit         en;
      logic [7:0] din;
      logic [7:0] word;
      logic [7:0] pc;
      bit         clr;
      bit         cfg;
      logic [1:0] ma;
      bit         mb;
      logic [3:0] dirs;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelStep(input bit r, input bit e, input int d);
      int idx;
      bit wr;
      if (r) begin
         m_word = 8'h9B; m_pc8 = 0; m_pc4 = 0; m_cfg = 0;
         m_clr = 0; m_err8 = 0; m_err4 = 0; m_prev_en = 0;
         return;
      end
      wr = e && !m_prev_en;
      m_prev_en = e;
      m_clr = 0; m_err8 = 0; m_err4 = 0;
      if (!wr) return;
      if (d >= 128) begin
         m_word = d; m_pc8 = 0; m_pc4 = 0; m_clr = 1; m_cfg = 1;
      end else begin
         idx = (d / 2) % 8;
         if (idx < 8) m_pc8 = (d % 2) ? (m_pc8 | (1 << idx)) : (m_pc8 & ~(1 << idx));
         else m_err8 = 1;
         if (idx < 4) m_pc4 = (d % 2) ? (m_pc4 | (1 << idx)) : (m_pc4 & ~(1 << idx));
         else m_err4 = 1;
      end
   endtask

   task automatic checkOutput();
      int exp_ma;
      exp_ma = ((m_word / 64) % 2) ? 2 : (m_word / 32) % 2;
      chk("word8", word8, m_word);
      chk("word4", word4, m_word);
      chk("mode_a8", mode_a8, exp_ma);
      chk("mode_a4", mode_a4, exp_ma);
      chk("mode_b", {mode_b8, mode_b4}, ((m_word / 4) % 2) * 3);
      chk("dir_a", {dir_a8, dir_a4}, ((m_word / 16) % 2) * 3);
      chk("dir_cu", {dir_cu8, dir_cu4}, ((m_word / 8) % 2) * 3);
      chk("dir_b", {dir_b8, dir_b4}, ((m_word / 2) % 2) * 3);
      chk("dir_cl", {dir_cl8, dir_cl4}, (m_word % 2) * 3);
      chk("pc8", pc8, m_pc8);
      chk("pc4", pc4, m_pc4);
      chk("clr_latch", {clr8, clr4}, m_clr * 3);
      chk("cfg_valid", {cfg8, cfg4}, m_cfg * 3);
      chk("bsr_err8", err8, m_err8);
      chk("bsr_err4", err4, m_err4);
   endtask

   // One clock: drive at the falling edge, step the model at the rising edge, sample 1 later.
   task automatic applyStimulus(input bit r, input bit e, input logic [7:0] d);
      @(negedge clk);
      rst = r; en = e; din = d;
      @(posedge clk);
      modelStep(r, e, int'(d));
      #1;
      checkOutput();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; din = 8'h00;

      vecs[0]  = '{1, 0, 8'h00, 8'h9B, 8'h00, 0, 0, 2'd0, 0, 4'hF};
      vecs[1]  = '{0, 0, 8'h00, 8'h9B, 8'h00, 0, 0, 2'd0, 0, 4'hF};
      vecs[2]  = '{0, 1, 8'hC5, 8'hC5, 8'h00, 1, 1, 2'd2, 1, 4'h1};
      vecs[3]  = '{0, 0, 8'h00, 8'hC5, 8'h00, 0, 1, 2'd2, 1, 4'h1};
      vecs[4]  = '{0, 1, 8'h0B, 8'hC5, 8'h20, 0, 1, 2'd2, 1, 4'h1};
      vecs[5]  = '{0, 0, 8'h00, 8'hC5, 8'h20, 0, 1, 2'd2, 1, 4'h1};
      vecs[6]  = '{0, 1, 8'h01, 8'hC5, 8'h21, 0, 1, 2'd2, 1, 4'h1};
      vecs[7]  = '{0, 0, 8'h00, 8'hC5, 8'h21, 0, 1, 2'd2, 1, 4'h1};
      vecs[8]  = '{0, 1, 8'h80, 8'h80, 8'h00, 1, 1, 2'd0, 0, 4'h0};
      vecs[9]  = '{0, 0, 8'h00, 8'h80, 8'h00, 0, 1, 2'd0, 0, 4'h0};
      vecs[10] = '{0, 1, 8'h01, 8'h80, 8'h01, 0, 1, 2'd0, 0, 4'h0};
      vecs[11] = '{0, 1, 8'h01, 8'h80, 8'h01, 0, 1, 2'd0, 0, 4'h0};
      vecs[12] = '{0, 1, 8'h01, 8'h80, 8'h01, 0, 1, 2'd0, 0, 4'h0};
      vecs[13] = '{0, 1, 8'h01, 8'h80, 8'h01, 0, 1, 2'd0, 0, 4'h0};
      vecs[14] = '{0, 1, 8'h03, 8'h80, 8'h01, 0, 1, 2'd0, 0, 4'h0};
      vecs[15] = '{0, 0, 8'h00, 8'h80, 8'h01, 0, 1, 2'd0, 0, 4'h0};

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].din);
         chk($sformatf("vec%0d.word", i), word8, vecs[i].word);
         chk($sformatf("vec%0d.pc", i), pc8, vecs[i].pc);
         chk($sformatf("vec%0d.clr", i), clr8, vecs[i].clr);
         chk($sformatf("vec%0d.cfg", i), cfg8, vecs[i].cfg);
         chk($sformatf("vec%0d.mode_a", i), mode_a8, vecs[i].ma);
         chk($sformatf("vec%0d.mode_b", i), mode_b8, vecs[i].mb);
         chk($sformatf("vec%0d.dirs", i), {dir_a8, dir_b8, dir_cu8, dir_cl8}, vecs[i].dirs);
         chk($sformatf("vec%0d.err", i), err8, 1'b0);
      end

      // Fill the 4-bit latch, then address bit 6: it must be refused with a one-cycle error.
      applyStimulus(0, 1, 8'h80);
      applyStimulus(0, 0, 8'h00);
      for (int b = 0; b < 4; b++) begin
         applyStimulus(0, 1, 8'(b * 2 + 1));
         applyStimulus(0, 0, 8'h00);
      end
      chk("pc4_full", pc4, 4'hF);
      applyStimulus(0, 1, 8'h0C);
      chk("oor.pc4", pc4, 4'hF);
      chk("oor.err4", err4, 1'b1);
      chk("oor.err8", err8, 1'b0);
      chk("oor.pc8_bit6_cleared", pc8, 8'h0F);
      applyStimulus(0, 1, 8'h0C);
      chk("oor.err4_one_cycle", err4, 1'b0);
      applyStimulus(0, 0, 8'h00);

      // A write raised while reset is high is dropped, then taken on the first edge after release.
      applyStimulus(1, 1, 8'h80);
      chk("rstwr.word", word8, 8'h9B);
      chk("rstwr.cfg", cfg8, 1'b0);
      chk("rstwr.clr", clr8, 1'b0);
      applyStimulus(0, 1, 8'h80);
      chk("rstwr.accept_word", word8, 8'h80);
      chk("rstwr.accept_cfg", cfg8, 1'b1);
      chk("rstwr.accept_clr", clr8, 1'b1);
      applyStimulus(0, 0, 8'h00);

      // Asynchronous reset takes effect before the next clock edge.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async.word", word8, 8'h9B);
      chk("async.cfg", cfg8, 1'b0);
      modelStep(1, 0, 0);
      applyStimulus(1, 0, 8'h00);

      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                       8'($urandom_range(0, 255)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
